// File: rtl/lab4d_seq_pkg.sv
// Shared types and widths for the LAB4D readout sequencer.
package lab4d_seq_pkg;

  localparam int unsigned HDR_W  = 4;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FIFO_RST  = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_FILL = 3'd4,
    ST_LOCK      = 3'd5,
    ST_READY     = 3'd6,
    ST_UNLOCK    = 3'd7
  } state_t;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/lab4d_trig_queue.sv
// Small synchronous FIFO of trigger header tags; wrap-bit pointers give full/empty.
module lab4d_trig_queue
  import lab4d_seq_pkg::*;
#(
  parameter int unsigned QDEPTH_LOG2 = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [HDR_W-1:0]       data_i,
  input  logic                   pop_i,
  output logic [HDR_W-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [QDEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 1 << QDEPTH_LOG2;
  localparam int unsigned PTR_W = QDEPTH_LOG2 + 1;

  logic [HDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (r_wptr == r_rptr);
  assign full_o    = (r_wptr[QDEPTH_LOG2] != r_rptr[QDEPTH_LOG2]) &&
                     (r_wptr[QDEPTH_LOG2-1:0] == r_rptr[QDEPTH_LOG2-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign count_o   = r_wptr - r_rptr;
  assign data_o    = r_mem[r_rptr[QDEPTH_LOG2-1:0]];

  // Pointer update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Header storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr[QDEPTH_LOG2-1:0]] <= data_i;
  end

endmodule

// File: rtl/lab4d_readout_sequencer.sv
// Runs one FIFO-reset / readout / fill / DMA-handoff cycle per queued trigger.
module lab4d_readout_sequencer
  import lab4d_seq_pkg::*;
#(
  parameter int unsigned NLAB            = 12,
  parameter int unsigned QDEPTH_LOG2     = 2,
  parameter int unsigned FIFO_RST_CYCLES = 8,
  parameter int unsigned DONE_TIMEOUT    = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   trig_i,
  input  logic [HDR_W-1:0]       trig_header_i,
  output logic                   readout_o,
  output logic [HDR_W-1:0]       readout_header_o,
  output logic                   readout_rst_o,
  output logic                   readout_fifo_rst_o,
  input  logic                   complete_i,
  input  logic [NLAB-1:0]        readout_fifo_empty_i,
  output logic                   dma_lock_o,
  input  logic                   dma_locked_i,
  output logic                   event_ready_o,
  input  logic                   event_ack_i,
  output logic [QDEPTH_LOG2:0]   pending_o,
  output logic [DROP_W-1:0]      dropped_o,
  output logic                   timeout_o,
  output logic                   busy_o,
  output logic [ST_W-1:0]        state_o
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(FIFO_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DONE_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort_pend;
  logic             w_abort;
  logic             w_pop;
  logic             w_push_req;
  logic             w_drop;
  logic             w_q_full;
  logic             w_q_empty;
  logic [HDR_W-1:0] w_q_head;
  logic             w_fill_done;
  logic             w_readout_nxt;
  logic             w_fifo_rst_nxt;
  logic             w_dma_lock_nxt;
  logic             w_event_ready_nxt;
  logic             w_busy_nxt;

  assign w_push_req  = trig_i && enable_i;
  assign w_drop      = w_push_req && w_q_full && !w_pop;
  assign w_fill_done = ~|readout_fifo_empty_i;
  assign state_o     = r_state;

  lab4d_trig_queue #(
    .QDEPTH_LOG2 (QDEPTH_LOG2)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push_req),
    .data_i  (trig_header_i),
    .pop_i   (w_pop),
    .data_o  (w_q_head),
    .full_o  (w_q_full),
    .empty_o (w_q_empty),
    .count_o (pending_o)
  );

  // State, shared dwell counter and abort-return flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (w_abort) begin
        r_abort_pend <= 1'b1;
      end else if (r_state == ST_FIFO_RST && w_state_nxt != ST_FIFO_RST) begin
        r_abort_pend <= 1'b0;
      end
    end
  end

  // Next-state decode; abort re-enters FIFO_RST and then returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_q_empty && !dma_locked_i) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_FIFO_RST;
        end
      end
      ST_FIFO_RST: begin
        if (r_cnt == RST_LAST) w_state_nxt = r_abort_pend ? ST_IDLE : ST_START;
      end
      ST_START: w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (complete_i) begin
          w_state_nxt = ST_WAIT_FILL;
        end else if (r_cnt == TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_FIFO_RST;
        end
      end
      ST_WAIT_FILL: begin
        if (w_fill_done) begin
          w_state_nxt = ST_LOCK;
        end else if (r_cnt == TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_FIFO_RST;
        end
      end
      ST_LOCK:   if (dma_locked_i)  w_state_nxt = ST_READY;
      ST_READY:  if (event_ack_i)   w_state_nxt = ST_UNLOCK;
      ST_UNLOCK: if (!dma_locked_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    w_readout_nxt     = (w_state_nxt == ST_START);
    w_fifo_rst_nxt    = (w_state_nxt == ST_FIFO_RST);
    w_dma_lock_nxt    = (w_state_nxt == ST_LOCK) || (w_state_nxt == ST_READY);
    w_event_ready_nxt = (w_state_nxt == ST_READY);
    w_busy_nxt        = (w_state_nxt != ST_IDLE);
  end

  // Output registers, header latch, sticky timeout and drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      readout_o          <= 1'b0;
      readout_rst_o      <= 1'b0;
      readout_fifo_rst_o <= 1'b0;
      dma_lock_o         <= 1'b0;
      event_ready_o      <= 1'b0;
      busy_o             <= 1'b0;
      timeout_o          <= 1'b0;
      readout_header_o   <= '0;
      dropped_o          <= '0;
    end else begin
      readout_o          <= w_readout_nxt;
      readout_rst_o      <= w_abort;
      readout_fifo_rst_o <= w_fifo_rst_nxt;
      dma_lock_o         <= w_dma_lock_nxt;
      event_ready_o      <= w_event_ready_nxt;
      busy_o             <= w_busy_nxt;
      if (w_abort) timeout_o        <= 1'b1;
      if (w_pop)   readout_header_o <= w_q_head;
      if (w_drop)  dropped_o        <= sat_inc(dropped_o);
    end
  end

endmodule

// File: tb/tb_lab4d_readout_sequencer.sv
// Randomized scenario bench for the LAB4D readout sequencer with a queue-level model.
module tb_lab4d_readout_sequencer;

  localparam int unsigned NLAB   = 12;
  localparam int unsigned QL     = 2;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned FRC    = 8;
  localparam int unsigned TMO    = 100;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            enable_i;
  logic            trig_i;
  logic [3:0]      trig_header_i;
  logic            readout_o;
  logic [3:0]      readout_header_o;
  logic            readout_rst_o;
  logic            readout_fifo_rst_o;
  logic            complete_i;
  logic [NLAB-1:0] readout_fifo_empty_i;
  logic            dma_lock_o;
  logic            dma_locked_i;
  logic            event_ready_o;
  logic            event_ack_i;
  logic [QL:0]     pending_o;
  logic [15:0]     dropped_o;
  logic            timeout_o;
  logic            busy_o;
  logic [2:0]      state_o;

  lab4d_readout_sequencer #(
    .NLAB(NLAB), .QDEPTH_LOG2(QL), .FIFO_RST_CYCLES(FRC), .DONE_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .trig_i(trig_i),
    .trig_header_i(trig_header_i), .readout_o(readout_o),
    .readout_header_o(readout_header_o), .readout_rst_o(readout_rst_o),
    .readout_fifo_rst_o(readout_fifo_rst_o), .complete_i(complete_i),
    .readout_fifo_empty_i(readout_fifo_empty_i), .dma_lock_o(dma_lock_o),
    .dma_locked_i(dma_locked_i), .event_ready_o(event_ready_o),
    .event_ack_i(event_ack_i), .pending_o(pending_o), .dropped_o(dropped_o),
    .timeout_o(timeout_o), .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: header queue in arrival order plus drop count.
  logic [3:0] mq[$];
  int         m_drop;
  bit         g_popped, prev_frst, g_rand;
  logic [3:0] g_pop_hdr;
  int         n_cmp, n_err;

  // One clock: sample requests before the edge, then update the model.
  task automatic tick();
    bit req; int sz; logic [3:0] h;
    req = trig_i && enable_i; sz = mq.size(); h = trig_header_i;
    @(posedge clk); #1;
    trig_i = 1'b0;
    g_popped = readout_fifo_rst_o && !prev_frst && !readout_rst_o;
    prev_frst = readout_fifo_rst_o;
    if (g_popped) begin
      n_cmp++;
      if (mq.size() == 0) begin n_err++; $display("FAIL pop_empty_queue got=pop exp=no_pop"); end
      else g_pop_hdr = mq.pop_front();
    end
    if (req) begin
      if (sz < QDEPTH || g_popped) mq.push_back(h);
      else if (m_drop < 65535) m_drop++;
    end
  endtask

  // Clock with optional random trigger traffic.
  task automatic cyc();
    if (g_rand) begin
      trig_i = ($urandom_range(0, 3) == 0);
      enable_i = ($urandom_range(0, 4) != 0);
      trig_header_i = 4'($urandom);
    end
    tick();
  endtask

  task automatic push_trig(input logic [3:0] h);
    trig_i = 1'b1; enable_i = 1'b1; trig_header_i = h;
    cyc();
  endtask

  task automatic wait_pop();
    int n;
    n = 0;
    while (!g_popped && n < 6) begin cyc(); n++; end
    n_cmp++;
    if (!g_popped) begin n_err++; $display("FAIL wait_pop got=no_pop exp=pop pending=%0d", pending_o); end
  endtask

  // Plays the readout/DMA side of one event starting in its first FIFO_RST cycle.
  // mode: 0 normal, 1 complete never comes, 2 one FIFO stays empty, 3 stop in READY.
  task automatic serve(input logic [3:0] exp, input int mode, input int done_dly,
                       input int fill_dly, input int lock_dly);
    int n; bit lock_seen;
    n = 0;
    while (readout_fifo_rst_o && n < 50) begin n++; cyc(); end
    n_cmp++; if (n != FRC) begin n_err++; $display("FAIL fifo_rst_len got=%0d exp=%0d", n, FRC); end
    n_cmp++; if (readout_o !== 1'b1 || state_o !== 3'd2) begin n_err++; $display("FAIL start_strobe got=%0b/%0d exp=1/2", readout_o, state_o); end
    n_cmp++; if (readout_header_o !== exp) begin n_err++; $display("FAIL start_header got=%0h exp=%0h", readout_header_o, exp); end
    cyc();
    n_cmp++; if (readout_o !== 1'b0 || state_o !== 3'd3) begin n_err++; $display("FAIL start_single got=%0b/%0d exp=0/3", readout_o, state_o); end
    if (mode == 1) begin
      n = 0;
      while (!readout_rst_o && n < 400) begin cyc(); n++; end
      n_cmp++; if (n != TMO) begin n_err++; $display("FAIL done_timeout_len got=%0d exp=%0d", n, TMO); end
    end else begin
      repeat (done_dly - 2) cyc();
      complete_i = 1'b1; cyc(); complete_i = 1'b0;
      n_cmp++; if (state_o !== 3'd4) begin n_err++; $display("FAIL enter_wait_fill got=%0d exp=4", state_o); end
      if (mode == 2) begin
        readout_fifo_empty_i = NLAB'(1) << $urandom_range(0, NLAB - 1);
        n = 0; lock_seen = 1'b0;
        while (!readout_rst_o && n < 400) begin cyc(); n++; if (dma_lock_o) lock_seen = 1'b1; end
        n_cmp++; if (n != TMO) begin n_err++; $display("FAIL fill_timeout_len got=%0d exp=%0d", n, TMO); end
        n_cmp++; if (lock_seen) begin n_err++; $display("FAIL fill_abort_lock got=1 exp=0"); end
      end
    end
    if (mode == 1 || mode == 2) begin
      n_cmp++; if (readout_rst_o !== 1'b1 || timeout_o !== 1'b1 || readout_fifo_rst_o !== 1'b1 || dma_lock_o !== 1'b0)
        begin n_err++; $display("FAIL abort_outputs got=rst%0b tmo%0b frst%0b lock%0b exp=1110", readout_rst_o, timeout_o, readout_fifo_rst_o, dma_lock_o); end
      cyc();
      n_cmp++; if (readout_rst_o !== 1'b0) begin n_err++; $display("FAIL abort_rst_pulse got=%0b exp=0", readout_rst_o); end
      n = 1;
      while (readout_fifo_rst_o && n < 50) begin n++; cyc(); end
      n_cmp++; if (n != FRC) begin n_err++; $display("FAIL abort_fifo_rst_len got=%0d exp=%0d", n, FRC); end
      n_cmp++; if (state_o !== 3'd0 || readout_o !== 1'b0) begin n_err++; $display("FAIL abort_to_idle got=%0d/%0b exp=0/0", state_o, readout_o); end
      readout_fifo_empty_i = '1;
      return;
    end
    repeat (fill_dly - 1) cyc();
    readout_fifo_empty_i = '0; cyc();
    n_cmp++; if (state_o !== 3'd5 || dma_lock_o !== 1'b1 || event_ready_o !== 1'b0) begin n_err++; $display("FAIL enter_lock got=%0d/%0b/%0b exp=5/1/0", state_o, dma_lock_o, event_ready_o); end
    event_ack_i = 1'b1; cyc(); event_ack_i = 1'b0;
    n_cmp++; if (state_o !== 3'd5) begin n_err++; $display("FAIL ack_in_lock_ignored got=%0d exp=5", state_o); end
    repeat (lock_dly - 2) cyc();
    dma_locked_i = 1'b1; cyc();
    n_cmp++; if (state_o !== 3'd6 || event_ready_o !== 1'b1 || dma_lock_o !== 1'b1) begin n_err++; $display("FAIL enter_ready got=%0d/%0b/%0b exp=6/1/1", state_o, event_ready_o, dma_lock_o); end
    if (mode == 3) return;
    repeat ($urandom_range(1, 4)) begin
      cyc();
      n_cmp++; if (event_ready_o !== 1'b1) begin n_err++; $display("FAIL ready_hold got=%0b exp=1", event_ready_o); end
    end
    event_ack_i = 1'b1; cyc(); event_ack_i = 1'b0;
    n_cmp++; if (state_o !== 3'd7 || dma_lock_o !== 1'b0 || event_ready_o !== 1'b0) begin n_err++; $display("FAIL enter_unlock got=%0d/%0b/%0b exp=7/0/0", state_o, dma_lock_o, event_ready_o); end
    repeat ($urandom_range(1, 3)) cyc();
    n_cmp++; if (state_o !== 3'd7) begin n_err++; $display("FAIL unlock_wait got=%0d exp=7", state_o); end
    dma_locked_i = 1'b0; cyc();
    n_cmp++; if (state_o !== 3'd0 || busy_o !== 1'b0) begin n_err++; $display("FAIL back_to_idle got=%0d/%0b exp=0/0", state_o, busy_o); end
    n_cmp++; if (readout_header_o !== exp) begin n_err++; $display("FAIL header_stable got=%0h exp=%0h", readout_header_o, exp); end
    readout_fifo_empty_i = '1;
  endtask

  // Serve queued events in order until the model queue runs dry.
  task automatic drain(input int max_ev);
    for (int e = 0; e < max_ev; e++) begin
      if (!g_popped) begin
        if (mq.size() == 0) begin
          repeat (3) cyc();
          if (!g_popped) break;
        end else wait_pop();
      end
      if (!g_popped) break;
      serve(g_pop_hdr, 0, $urandom_range(2, 30), $urandom_range(1, 12), $urandom_range(2, 5));
      n_cmp++; if (pending_o !== 3'(mq.size()) || dropped_o !== 16'(m_drop))
        begin n_err++; $display("FAIL drain_counts got=%0d/%0d exp=%0d/%0d", pending_o, dropped_o, mq.size(), m_drop); end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; trig_i = 1'b0; trig_header_i = '0; complete_i = 1'b0;
    readout_fifo_empty_i = '1; dma_locked_i = 1'b0; event_ack_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if ({readout_o, readout_rst_o, readout_fifo_rst_o, dma_lock_o, event_ready_o, timeout_o, busy_o} !== 7'd0)
      begin n_err++; $display("FAIL reset_strobes got=%07b exp=0000000", {readout_o, readout_rst_o, readout_fifo_rst_o, dma_lock_o, event_ready_o, timeout_o, busy_o}); end
    n_cmp++; if (state_o !== 3'd0 || pending_o !== '0 || dropped_o !== '0 || readout_header_o !== '0)
      begin n_err++; $display("FAIL reset_state got=%0d/%0d/%0d/%0h exp=0/0/0/0", state_o, pending_o, dropped_o, readout_header_o); end
    rst_i = 1'b0; mq.delete(); m_drop = 0; prev_frst = 1'b0; g_popped = 1'b0;
    enable_i = 1'b1;
    cyc();
  endtask

  task automatic test_single_event();
    push_trig(4'hA);
    n_cmp++; if (state_o !== 3'd0 || pending_o !== 3'd1) begin n_err++; $display("FAIL single_queued got=%0d/%0d exp=0/1", state_o, pending_o); end
    cyc();
    n_cmp++; if (state_o !== 3'd1 || readout_fifo_rst_o !== 1'b1 || pending_o !== 3'd0) begin n_err++; $display("FAIL single_fifo_rst got=%0d/%0b/%0d exp=1/1/0", state_o, readout_fifo_rst_o, pending_o); end
    serve(4'hA, 0, 50, 10, 2);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = m_drop;
    dma_locked_i = 1'b1;
    for (int i = 0; i < 6; i++) push_trig(4'($urandom));
    n_cmp++; if (pending_o !== 3'd4 || dropped_o !== 16'(d0 + 2)) begin n_err++; $display("FAIL b2b_full got=%0d/%0d exp=4/%0d", pending_o, dropped_o, d0 + 2); end
    dma_locked_i = 1'b0;
    drain(10);
    n_cmp++; if (pending_o !== 3'd0) begin n_err++; $display("FAIL b2b_empty got=%0d exp=0", pending_o); end
  endtask

  task automatic test_push_pop_full();
    int d0;
    d0 = m_drop;
    dma_locked_i = 1'b1;
    for (int i = 0; i < 4; i++) push_trig(4'($urandom));
    dma_locked_i = 1'b0;
    push_trig(4'($urandom));
    n_cmp++; if (pending_o !== 3'd4 || dropped_o !== 16'(d0) || state_o !== 3'd1) begin n_err++; $display("FAIL push_pop_full got=%0d/%0d/%0d exp=4/%0d/1", pending_o, dropped_o, state_o, d0); end
    serve(g_pop_hdr, 0, $urandom_range(2, 20), $urandom_range(1, 8), 2);
    drain(10);
  endtask

  task automatic test_done_timeout();
    dma_locked_i = 1'b1;
    push_trig(4'($urandom)); push_trig(4'($urandom));
    dma_locked_i = 1'b0;
    wait_pop();
    serve(g_pop_hdr, 1, 0, 0, 0);
    n_cmp++; if (pending_o !== 3'd1 || timeout_o !== 1'b1) begin n_err++; $display("FAIL done_abort_queue got=%0d/%0b exp=1/1", pending_o, timeout_o); end
    drain(5);
  endtask

  task automatic test_fill_timeout();
    push_trig(4'($urandom));
    wait_pop();
    serve(g_pop_hdr, 2, $urandom_range(2, 20), 0, 0);
    n_cmp++; if (pending_o !== 3'd0 || timeout_o !== 1'b1) begin n_err++; $display("FAIL fill_abort_queue got=%0d/%0b exp=0/1", pending_o, timeout_o); end
  endtask

  task automatic test_random();
    g_rand = 1'b1;
    push_trig(4'($urandom));
    drain(8);
    g_rand = 1'b0; enable_i = 1'b1;
    drain(20);
    n_cmp++; if (pending_o !== 3'(mq.size()) || dropped_o !== 16'(m_drop)) begin n_err++; $display("FAIL random_counts got=%0d/%0d exp=%0d/%0d", pending_o, dropped_o, mq.size(), m_drop); end
  endtask

  task automatic test_rst_in_ready();
    logic [3:0] h;
    dma_locked_i = 1'b1;
    for (int i = 0; i < 6; i++) push_trig(4'($urandom));
    dma_locked_i = 1'b0;
    wait_pop();
    serve(g_pop_hdr, 3, $urandom_range(2, 10), $urandom_range(1, 5), 2);
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if (dma_lock_o !== 1'b0 || event_ready_o !== 1'b0 || state_o !== 3'd0) begin n_err++; $display("FAIL async_rst_outputs got=%0b/%0b/%0d exp=0/0/0", dma_lock_o, event_ready_o, state_o); end
    n_cmp++; if (pending_o !== 3'd0 || dropped_o !== 16'd0 || timeout_o !== 1'b0) begin n_err++; $display("FAIL async_rst_counts got=%0d/%0d/%0b exp=0/0/0", pending_o, dropped_o, timeout_o); end
    @(posedge clk); #1;
    rst_i = 1'b0; dma_locked_i = 1'b0; readout_fifo_empty_i = '1;
    mq.delete(); m_drop = 0; prev_frst = 1'b0; g_popped = 1'b0;
    h = 4'($urandom);
    push_trig(h);
    wait_pop();
    n_cmp++; if (g_pop_hdr !== h) begin n_err++; $display("FAIL post_rst_order got=%0h exp=%0h", g_pop_hdr, h); end
    serve(h, 0, 5, 3, 2);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; g_rand = 1'b0;
    test_reset();
    test_single_event();
    test_back_to_back();
    test_push_pop_full();
    test_done_timeout();
    test_fill_timeout();
    test_random();
    test_rst_in_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
